// File: rtl/simple_gen_weight_store.sv
// Run-time loadable weight/bias store for simple_generator: four registered ROM-style
// read ports backed by register files filled from a host valid/ready word stream.
`timescale 1ns/1ps

module simple_gen_weight_store #(
  parameter int LATENT_DIM   = 2,
  parameter int HIDDEN_SIZE  = 3,
  parameter int OUTPUT_SIZE  = 9,
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load_start,
  input  logic                           load_valid,
  input  logic [DATA_WIDTH-1:0]          load_data,
  output logic                           load_ready,
  output logic                           load_done,
  output logic                           params_valid,
  output logic                           range_err,
  output logic [DATA_WIDTH-1:0]          checksum,
  input  logic [3:0]                     w1_addr,
  output logic signed [WEIGHT_WIDTH-1:0] w1_data,
  input  logic [1:0]                     b1_addr,
  output logic signed [DATA_WIDTH-1:0]   b1_data,
  input  logic [4:0]                     w2_addr,
  output logic signed [WEIGHT_WIDTH-1:0] w2_data,
  input  logic [3:0]                     b2_addr,
  output logic signed [DATA_WIDTH-1:0]   b2_data
);

  localparam int N_W1 = LATENT_DIM * HIDDEN_SIZE;
  localparam int N_B1 = HIDDEN_SIZE;
  localparam int N_W2 = HIDDEN_SIZE * OUTPUT_SIZE;
  localparam int N_B2 = OUTPUT_SIZE;

  typedef enum logic [2:0] {IDLE, LD_W1, LD_B1, LD_W2, LD_B2} state_t;

  state_t state, state_next;
  logic [4:0] counter, counter_next;

  logic [WEIGHT_WIDTH-1:0] w1_mem [N_W1];
  logic [DATA_WIDTH-1:0]   b1_mem [N_B1];
  logic [WEIGHT_WIDTH-1:0] w2_mem [N_W2];
  logic [DATA_WIDTH-1:0]   b2_mem [N_B2];

  logic in_load, last_word, accept, final_accept, is_weight, weight_bad;
  logic [WEIGHT_WIDTH-1:0] w1_rd, w2_rd;
  logic [DATA_WIDTH-1:0]   b1_rd, b2_rd;

  assign in_load      = (state != IDLE);
  assign load_ready   = in_load;
  assign last_word    = (state == LD_B2) && (counter == 5'(N_B2 - 1));
  // A word coinciding with load_start is dropped, except the very last one of a load.
  assign accept       = load_valid && in_load && (!load_start || last_word);
  assign final_accept = accept && last_word;
  assign is_weight    = (state == LD_W1) || (state == LD_W2);
  assign weight_bad   = !((&load_data[DATA_WIDTH-1:WEIGHT_WIDTH-1]) ||
                          (~|load_data[DATA_WIDTH-1:WEIGHT_WIDTH-1]));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    if (load_start) begin
      state_next   = LD_W1;
      counter_next = '0;
    end else if (accept) begin
      counter_next = counter + 5'd1;
      case (state)
        LD_W1: if (counter == 5'(N_W1 - 1)) begin
          state_next   = LD_B1;
          counter_next = '0;
        end
        LD_B1: if (counter == 5'(N_B1 - 1)) begin
          state_next   = LD_W2;
          counter_next = '0;
        end
        LD_W2: if (counter == 5'(N_W2 - 1)) begin
          state_next   = LD_B2;
          counter_next = '0;
        end
        LD_B2: if (counter == 5'(N_B2 - 1)) begin
          state_next   = IDLE;
          counter_next = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_W1; i++) w1_mem[i] <= '0;
      for (int i = 0; i < N_B1; i++) b1_mem[i] <= '0;
      for (int i = 0; i < N_W2; i++) w2_mem[i] <= '0;
      for (int i = 0; i < N_B2; i++) b2_mem[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < N_W1; i++)
        if (state == LD_W1 && counter == 5'(i)) w1_mem[i] <= load_data[WEIGHT_WIDTH-1:0];
      for (int i = 0; i < N_B1; i++)
        if (state == LD_B1 && counter == 5'(i)) b1_mem[i] <= load_data;
      for (int i = 0; i < N_W2; i++)
        if (state == LD_W2 && counter == 5'(i)) w2_mem[i] <= load_data[WEIGHT_WIDTH-1:0];
      for (int i = 0; i < N_B2; i++)
        if (state == LD_B2 && counter == 5'(i)) b2_mem[i] <= load_data;
    end
  end

  // Restart clears load status last so it wins over a coincident final accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_done    <= 1'b0;
      params_valid <= 1'b0;
      range_err    <= 1'b0;
      checksum     <= '0;
    end else begin
      load_done <= 1'b0;
      if (accept) begin
        checksum <= checksum + load_data;
        if (is_weight && weight_bad) range_err <= 1'b1;
      end
      if (final_accept) begin
        load_done    <= 1'b1;
        params_valid <= 1'b1;
      end
      if (load_start) begin
        checksum     <= '0;
        range_err    <= 1'b0;
        params_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    w1_rd = '0;
    b1_rd = '0;
    w2_rd = '0;
    b2_rd = '0;
    for (int i = 0; i < N_W1; i++) if (w1_addr == 4'(i)) w1_rd = w1_mem[i];
    for (int i = 0; i < N_B1; i++) if (b1_addr == 2'(i)) b1_rd = b1_mem[i];
    for (int i = 0; i < N_W2; i++) if (w2_addr == 5'(i)) w2_rd = w2_mem[i];
    for (int i = 0; i < N_B2; i++) if (b2_addr == 4'(i)) b2_rd = b2_mem[i];
  end

  // Reads are blanked during a load so a half-written parameter set is never served.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w1_data <= '0;
      b1_data <= '0;
      w2_data <= '0;
      b2_data <= '0;
    end else begin
      w1_data <= in_load ? '0 : w1_rd;
      b1_data <= in_load ? '0 : b1_rd;
      w2_data <= in_load ? '0 : w2_rd;
      b2_data <= in_load ? '0 : b2_rd;
    end
  end

endmodule
